// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types, widths and helpers for the PLL reconfiguration controller
package pll_ctrl_pkg;

    localparam int DIV_W   = 10;
    localparam int PHASE_W = 13;

    typedef enum logic [2:0] {
        IDLE,
        PWD,
        APPLY,
        RST,
        WAIT_LOCK,
        LOCKED,
        ERROR
    } state_e;

    // One complete PLL dynamic configuration word (shadow and live copies)
    typedef struct packed {
        logic [DIV_W-1:0]   idiv;
        logic [DIV_W-1:0]   fdiv;
        logic [DIV_W-1:0]   odiv;
        logic [DIV_W-1:0]   duty;
        logic [PHASE_W-1:0] phase;
    } pll_cfg_t;

    // Bits needed for a counter running 0 .. n-1 (never less than one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sequence counter width: the lock timeout dominates, but the
    // power-down and reset phases share the same counter
    function automatic int seq_cnt_width(input int lock_timeout, input int pwd_cycles,
                                         input int rst_cycles);
        int m;
        m = lock_timeout;
        if (pwd_cycles > m) m = pwd_cycles;
        if (rst_cycles > m) m = rst_cycles;
        return cnt_width(m);
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// rtl/pll_reconfig_ctrl_if.sv - configuration request/ready bus between register block and PLL controller
interface pll_reconfig_ctrl_if;
    import pll_ctrl_pkg::*;

    logic               cfg_req;
    logic               cfg_ready;
    logic [DIV_W-1:0]   cfg_idiv;
    logic [DIV_W-1:0]   cfg_fdiv;
    logic [DIV_W-1:0]   cfg_odiv;
    logic [DIV_W-1:0]   cfg_duty;
    logic [PHASE_W-1:0] cfg_phase;

    modport master (
        output cfg_req, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_req, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty, cfg_phase,
        output cfg_ready
    );

endinterface

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - 2-FF lock synchronizer and consecutive-high stability counter
module pll_lock_sync #(
    parameter int LOCK_STABLE = 8
) (
    input  logic clk_tb,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic clr,
    output logic lock_s,
    output logic lock_stable_hit
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [SW-1:0] stable_q, stable_d;

    // Synchronizer shift and saturating run-length count of lock_s high
    always_comb begin
        sync1_d  = pll_lock;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        if (clr || !sync2_q) begin
            stable_d = '0;
        end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + 1'b1;
        end
    end

    // Synchronizer and counter flops
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
        end
    end

    assign lock_s          = sync2_q;
    // Fires on the LOCK_STABLE-th consecutive high cycle
    assign lock_stable_hit = sync2_q && !clr && (stable_q == STABLE_LAST);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - PLL power-down/apply/reset/lock sequencer; optional PLL_LOCK_LOSS_RECOVER_EN
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                 PWD_CYCLES   = 16,
    parameter int                 RST_CYCLES   = 16,
    parameter int                 LOCK_STABLE  = 8,
    parameter int                 LOCK_TIMEOUT = 50000,
    parameter int                 MAX_RETRY    = 3,
    parameter logic [DIV_W-1:0]   DEF_IDIV     = 10'd2,
    parameter logic [DIV_W-1:0]   DEF_FDIV     = 10'd32,
    parameter logic [DIV_W-1:0]   DEF_ODIV     = 10'd100,
    parameter logic [DIV_W-1:0]   DEF_DUTY     = 10'd100,
    parameter logic [PHASE_W-1:0] DEF_PHASE    = 13'd16
) (
    input  logic                clk_tb,
    input  logic                rst_n,
    pll_reconfig_ctrl_if.slave  cfg,
    input  logic                pll_lock,
    output logic                pll_pwd,
    output logic                pll_rst,
    output logic [DIV_W-1:0]    dyn_idiv,
    output logic [DIV_W-1:0]    dyn_fdiv,
    output logic [DIV_W-1:0]    dyn_odiv,
    output logic [DIV_W-1:0]    dyn_duty,
    output logic [PHASE_W-1:0]  dyn_phase,
    output logic                busy,
    output logic                locked,
    output logic                err,
    output logic [1:0]          retry_cnt,
    output logic                lock_lost
);

    localparam int CNT_W = seq_cnt_width(LOCK_TIMEOUT, PWD_CYCLES, RST_CYCLES);
    localparam logic [CNT_W-1:0] PWD_LAST  = CNT_W'(PWD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);
    localparam pll_cfg_t DEF_CFG = '{DEF_IDIV, DEF_FDIV, DEF_ODIV, DEF_DUTY, DEF_PHASE};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    pll_cfg_t         shadow_q, shadow_d;
    pll_cfg_t         dyn_q, dyn_d;
    logic             pwd_q, pwd_d;
    logic             prst_q, prst_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             lost_q, lost_d;

    logic             lock_s;
    logic             stable_hit;
    logic             accept;
    logic             timeout;

    pll_lock_sync #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_sync (
        .clk_tb          (clk_tb),
        .rst_n           (rst_n),
        .pll_lock        (pll_lock),
        .clr             (state_q != WAIT_LOCK),
        .lock_s          (lock_s),
        .lock_stable_hit (stable_hit)
    );

    assign accept  = cfg.cfg_req && ready_q;
    assign timeout = (cnt_q == TO_LAST);

    // State register: reset lands in PWD so bring-up starts on release
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; lock completion outranks a same-cycle timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ERROR: if (accept) state_d = PWD;
            PWD:         if (cnt_q == PWD_LAST) state_d = APPLY;
            APPLY:       state_d = RST;
            RST:         if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (stable_hit) begin
                    state_d = LOCKED;
                end else if (timeout) begin
                    state_d = (retry_q < RETRY_MAX) ? PWD : ERROR;
                end
            end
            LOCKED: begin
                if (accept) begin
                    state_d = PWD;
                end else if (!lock_s) begin
`ifdef PLL_LOCK_LOSS_RECOVER_EN
                    state_d = PWD;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = PWD;
        endcase
    end

    // Counters, shadow/live configuration and registered outputs from next state
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        retry_d  = retry_q;
        shadow_d = shadow_q;
        if (accept) begin
            shadow_d = '{cfg.cfg_idiv, cfg.cfg_fdiv, cfg.cfg_odiv, cfg.cfg_duty, cfg.cfg_phase};
            retry_d  = '0;
        end else if (state_q == WAIT_LOCK && state_d == PWD) begin
            retry_d = retry_q + 2'd1;
        end
`ifdef PLL_LOCK_LOSS_RECOVER_EN
        else if (state_q == LOCKED && !lock_s) begin
            retry_d = '0;
        end
`endif

        // Live PLL config only moves while the PLL is held in reset
        dyn_d = (state_d == APPLY) ? shadow_q : dyn_q;

        pwd_d    = (state_d == PWD);
        prst_d   = (state_d == PWD) || (state_d == APPLY) || (state_d == RST) ||
                   (state_d == ERROR);
        busy_d   = (state_d == PWD) || (state_d == APPLY) || (state_d == RST) ||
                   (state_d == WAIT_LOCK);
        ready_d  = (state_d == IDLE) || (state_d == LOCKED) || (state_d == ERROR);
        locked_d = (state_d == LOCKED);
        err_d    = (state_d == ERROR);
        lost_d   = (state_q == LOCKED) && !lock_s;
    end

    // Datapath and output registers
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            retry_q  <= '0;
            shadow_q <= DEF_CFG;
            dyn_q    <= DEF_CFG;
            pwd_q    <= 1'b1;
            prst_q   <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            shadow_q <= shadow_d;
            dyn_q    <= dyn_d;
            pwd_q    <= pwd_d;
            prst_q   <= prst_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            lost_q   <= lost_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign pll_pwd       = pwd_q;
    assign pll_rst       = prst_q;
    assign busy          = busy_q;
    assign locked        = locked_q;
    assign err           = err_q;
    assign retry_cnt     = retry_q;
    assign lock_lost     = lost_q;
    assign dyn_idiv      = dyn_q.idiv;
    assign dyn_fdiv      = dyn_q.fdiv;
    assign dyn_odiv      = dyn_q.odiv;
    assign dyn_duty      = dyn_q.duty;
    assign dyn_phase     = dyn_q.phase;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - directed self-checking bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;

    localparam int T_OUT = 300;

    logic        clk_tb = 1'b0;
    logic        rst_n;
    logic        pll_lock;
    logic        pll_pwd, pll_rst, busy, locked, err, lock_lost;
    logic [1:0]  retry_cnt;
    logic [9:0]  dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty;
    logic [12:0] dyn_phase;

    int n_cmp = 0;
    int n_err = 0;

    pll_reconfig_ctrl_if cfg_bus ();

    always #5 clk_tb = ~clk_tb;

    pll_reconfig_ctrl #(
        .LOCK_TIMEOUT (T_OUT)
    ) dut (
        .clk_tb    (clk_tb),
        .rst_n     (rst_n),
        .cfg       (cfg_bus),
        .pll_lock  (pll_lock),
        .pll_pwd   (pll_pwd),
        .pll_rst   (pll_rst),
        .dyn_idiv  (dyn_idiv),
        .dyn_fdiv  (dyn_fdiv),
        .dyn_odiv  (dyn_odiv),
        .dyn_duty  (dyn_duty),
        .dyn_phase (dyn_phase),
        .busy      (busy),
        .locked    (locked),
        .err       (err),
        .retry_cnt (retry_cnt),
        .lock_lost (lock_lost)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_tb);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [9:0] i, input logic [9:0] f, input logic [9:0] o,
                           input logic [9:0] d, input logic [12:0] p);
        cfg_bus.cfg_idiv  = i;
        cfg_bus.cfg_fdiv  = f;
        cfg_bus.cfg_odiv  = o;
        cfg_bus.cfg_duty  = d;
        cfg_bus.cfg_phase = p;
    endtask

    // Holds reset for two edges and releases it 1 time unit after an edge
    task automatic pulse_reset();
        rst_n = 1'b0;
        cfg_bus.cfg_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst_n = 1'b1;
        pll_lock = 1'b0;
        cfg_bus.cfg_req = 1'b0;
        set_cfg(10'd2, 10'd32, 10'd100, 10'd100, 13'd16);
        #2;
        rst_n = 1'b0;
        tick(2);
        obs = {pll_pwd, pll_rst, busy, cfg_bus.cfg_ready, locked, err, retry_cnt, lock_lost};
        n_cmp++;
        if (obs !== 9'b111_000_00_0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", obs, 9'b111_000_00_0);
        end
        n_cmp++;
        if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase} !== {10'd2, 10'd32, 10'd100, 10'd100, 13'd16}) begin
            n_err++;
            $display("FAIL reset_dyn: got %0d %0d %0d %0d %0d want 2 32 100 100 16",
                     dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            n_cmp++;
            if (pll_pwd !== (k < 16)) begin
                n_err++;
                $display("FAIL bringup_pwd tick %0d: got %b want %b", k, pll_pwd, (k < 16));
            end
            n_cmp++;
            if (pll_rst !== (k < 33)) begin
                n_err++;
                $display("FAIL bringup_rst tick %0d: got %b want %b", k, pll_rst, (k < 33));
            end
            if (k == 16) begin
                n_cmp++;
                if (dyn_odiv !== 10'd100 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL bringup_apply: odiv %0d busy %b want 100 1", dyn_odiv, busy);
                end
            end
        end
        tick(160);
        pll_lock = 1'b1;
        tick(9);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL bringup_lock_early: got %b want 0", locked);
        end
        tick(1);
        n_cmp++;
        if ({locked, busy, cfg_bus.cfg_ready, pll_rst, pll_pwd} !== 5'b10100) begin
            n_err++;
            $display("FAIL bringup_locked: got %b want 10100",
                     {locked, busy, cfg_bus.cfg_ready, pll_rst, pll_pwd});
        end
    endtask

    task automatic test_reconfig();
        set_cfg(10'd3, 10'd40, 10'd200, 10'd200, 13'd100);
        cfg_bus.cfg_req = 1'b1;
        tick(1);
        cfg_bus.cfg_req = 1'b0;
        n_cmp++;
        if ({cfg_bus.cfg_ready, busy, locked, pll_pwd} !== 4'b0101) begin
            n_err++;
            $display("FAIL reconfig_accept: got %b want 0101",
                     {cfg_bus.cfg_ready, busy, locked, pll_pwd});
        end
        for (int k = 1; k <= 45; k++) begin
            tick(1);
            n_cmp++;
            if (dyn_odiv !== ((k < 16) ? 10'd100 : 10'd200)) begin
                n_err++;
                $display("FAIL reconfig_odiv tick %0d: got %0d want %0d", k, dyn_odiv,
                         (k < 16) ? 100 : 200);
            end
            n_cmp++;
            if (locked !== (k >= 41)) begin
                n_err++;
                $display("FAIL reconfig_locked tick %0d: got %b want %b", k, locked, (k >= 41));
            end
            if (k == 16) begin
                n_cmp++;
                if ({pll_rst, pll_pwd} !== 2'b10) begin
                    n_err++;
                    $display("FAIL reconfig_apply_rst: got %b want 10", {pll_rst, pll_pwd});
                end
            end
        end
        n_cmp++;
        if ({dyn_idiv, dyn_fdiv, dyn_duty, dyn_phase} !== {10'd3, 10'd40, 10'd200, 13'd100}) begin
            n_err++;
            $display("FAIL reconfig_dyn: got %0d %0d %0d %0d want 3 40 200 100",
                     dyn_idiv, dyn_fdiv, dyn_duty, dyn_phase);
        end
    endtask

    task automatic test_lock_loss();
        pll_lock = 1'b0;
        tick(2);
        n_cmp++;
        if ({locked, lock_lost} !== 2'b10) begin
            n_err++;
            $display("FAIL loss_sync_delay: got %b want 10", {locked, lock_lost});
        end
        tick(1);
        n_cmp++;
        if ({locked, lock_lost} !== 2'b01) begin
            n_err++;
            $display("FAIL loss_pulse: got %b want 01", {locked, lock_lost});
        end
`ifdef PLL_LOCK_LOSS_RECOVER_EN
        n_cmp++;
        if ({pll_pwd, busy, retry_cnt} !== 4'b1100) begin
            n_err++;
            $display("FAIL loss_recover: got %b want 1100", {pll_pwd, busy, retry_cnt});
        end
`else
        n_cmp++;
        if ({pll_pwd, busy, cfg_bus.cfg_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL loss_idle: got %b want 001", {pll_pwd, busy, cfg_bus.cfg_ready});
        end
`endif
        tick(1);
        n_cmp++;
        if (lock_lost !== 1'b0) begin
            n_err++;
            $display("FAIL loss_single_pulse: got %b want 0", lock_lost);
        end
`ifndef PLL_LOCK_LOSS_RECOVER_EN
        tick(5);
        n_cmp++;
        if ({pll_pwd, pll_rst, dyn_odiv} !== {2'b00, 10'd200}) begin
            n_err++;
            $display("FAIL loss_pll_untouched: pwd %b rst %b odiv %0d want 0 0 200",
                     pll_pwd, pll_rst, dyn_odiv);
        end
`endif
    endtask

    task automatic test_timeout_retry();
        pll_lock = 1'b0;
        pulse_reset();
        for (int k = 1; k <= 1340; k++) begin
            tick(1);
            if (k == 332 || k == 333 || k == 665 || k == 666 || k == 999) begin
                n_cmp++;
                if (retry_cnt !== ((k < 333) ? 2'd0 : (k < 666) ? 2'd1 : (k < 999) ? 2'd2 : 2'd3)) begin
                    n_err++;
                    $display("FAIL retry_count tick %0d: got %0d", k, retry_cnt);
                end
            end
            if (k == 333) begin
                n_cmp++;
                if (pll_pwd !== 1'b1) begin
                    n_err++;
                    $display("FAIL retry_repwd: got %b want 1", pll_pwd);
                end
            end
            if (k == 1331) begin
                n_cmp++;
                if ({err, busy} !== 2'b01) begin
                    n_err++;
                    $display("FAIL error_early: got %b want 01", {err, busy});
                end
            end
            if (k == 1332 || k == 1340) begin
                n_cmp++;
                if ({err, pll_rst, pll_pwd, busy, cfg_bus.cfg_ready, retry_cnt} !== 7'b1100111) begin
                    n_err++;
                    $display("FAIL error_state tick %0d: got %b want 1100111", k,
                             {err, pll_rst, pll_pwd, busy, cfg_bus.cfg_ready, retry_cnt});
                end
            end
        end
        set_cfg(10'd2, 10'd32, 10'd150, 10'd100, 13'd16);
        cfg_bus.cfg_req = 1'b1;
        tick(1);
        cfg_bus.cfg_req = 1'b0;
        n_cmp++;
        if ({err, retry_cnt, busy, cfg_bus.cfg_ready} !== 5'b00010) begin
            n_err++;
            $display("FAIL error_clear: got %b want 00010",
                     {err, retry_cnt, busy, cfg_bus.cfg_ready});
        end
    endtask

    task automatic test_glitch();
        tick(40);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(4);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_no_early_lock: got %b want 0", locked);
        end
        tick(5);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_restart: got %b want 0", locked);
        end
        tick(1);
        n_cmp++;
        if ({locked, dyn_odiv} !== {1'b1, 10'd150}) begin
            n_err++;
            $display("FAIL glitch_locked: locked %b odiv %0d want 1 150", locked, dyn_odiv);
        end
    endtask

    task automatic test_reset_mid();
        int lock_tick;
        pll_lock = 1'b1;
        pulse_reset();
        lock_tick = 0;
        for (int k = 1; k <= 60 && lock_tick == 0; k++) begin
            tick(1);
            if (locked === 1'b1) lock_tick = k;
        end
        n_cmp++;
        if (lock_tick != 41) begin
            n_err++;
            $display("FAIL relock_time: got %0d want 41 (0 = timed out)", lock_tick);
        end
        set_cfg(10'd5, 10'd60, 10'd300, 10'd50, 13'd200);
        cfg_bus.cfg_req = 1'b1;
        tick(1);
        cfg_bus.cfg_req = 1'b0;
        tick(4);
        set_cfg(10'd7, 10'd70, 10'd500, 10'd70, 13'd700);
        cfg_bus.cfg_req = 1'b1;
        tick(1);
        cfg_bus.cfg_req = 1'b0;
        n_cmp++;
        if ({cfg_bus.cfg_ready, busy, pll_pwd} !== 3'b011) begin
            n_err++;
            $display("FAIL busy_req_ignored: got %b want 011", {cfg_bus.cfg_ready, busy, pll_pwd});
        end
        tick(14);
        n_cmp++;
        if ({pll_rst, pll_pwd, dyn_odiv, dyn_duty} !== {2'b10, 10'd300, 10'd50}) begin
            n_err++;
            $display("FAIL mid_rst_dyn: rst %b pwd %b odiv %0d duty %0d want 1 0 300 50",
                     pll_rst, pll_pwd, dyn_odiv, dyn_duty);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pll_pwd, pll_rst, busy, cfg_bus.cfg_ready, locked, err, retry_cnt, lock_lost} !== 9'b111_000_00_0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %b want 111000000",
                     {pll_pwd, pll_rst, busy, cfg_bus.cfg_ready, locked, err, retry_cnt, lock_lost});
        end
        n_cmp++;
        if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase} !== {10'd2, 10'd32, 10'd100, 10'd100, 13'd16}) begin
            n_err++;
            $display("FAIL async_reset_dyn: got %0d %0d %0d %0d %0d want 2 32 100 100 16",
                     dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase);
        end
        tick(1);
        rst_n = 1'b1;
        tick(16);
        n_cmp++;
        if ({pll_pwd, pll_rst, dyn_odiv, dyn_phase} !== {2'b01, 10'd100, 13'd16}) begin
            n_err++;
            $display("FAIL shadow_reverted: pwd %b rst %b odiv %0d phase %0d want 0 1 100 16",
                     pll_pwd, pll_rst, dyn_odiv, dyn_phase);
        end
    endtask

    initial begin
        test_reset();
        test_reconfig();
        test_lock_loss();
        test_timeout_retry();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
